coproc_batch_buffer: RTL



---
 rtl/coproc_batch_pkg.sv | 26 ++
 rtl/coproc_batch_packer.sv | 72 +++++++
 rtl/coproc_batch_buffer.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/coproc_batch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : coproc_batch_pkg
// Purpose  : Shared types, default geometry and width helper for the
//            coprocessor ping-pong batch buffer.
// Revision : 1.0 - initial release
// ============================================================================
package coproc_batch_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } bank_state_t;

    localparam int DEF_ELEM_W    = 8;
    localparam int DEF_ROW_ELEMS = 8;
    localparam int DEF_ROWS      = 8;

    // Index width with a floor of one bit so degenerate counts stay legal.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/coproc_batch_packer.sv
`default_nettype none
// ============================================================================
// Module   : coproc_batch_packer
// Purpose  : Element/row counters and lane strobes that pack write beats
//            into rows of the current write bank.
// Revision : 1.0 - initial release
// ============================================================================
module coproc_batch_packer
    import coproc_batch_pkg::*;
#(
    parameter int ROW_ELEMS = DEF_ROW_ELEMS,
    parameter int ROWS      = DEF_ROWS,
    parameter int ROW_AW    = idx_width(ROWS)
)(
    input  logic                 i_clk,
    input  logic                 i_clr,
    input  logic                 i_accept,
    input  logic                 i_flush,
    input  logic                 i_bank_filling,
    output logic [ROW_AW-1:0]    o_row,
    output logic [ROW_ELEMS-1:0] o_lane_we,
    output logic                 o_clear_row,
    output logic                 o_last,
    output logic                 o_commit,
    output logic [ROW_AW:0]      o_commit_rows
);

    localparam int E_W = idx_width(ROW_ELEMS);
    localparam int RW1 = ROW_AW + 1;
    localparam logic [E_W-1:0]    c_LAST_E = E_W'(ROW_ELEMS - 1);
    localparam logic [ROW_AW-1:0] c_LAST_R = ROW_AW'(ROWS - 1);

    logic [E_W-1:0]    r_elem;
    logic [ROW_AW-1:0] r_row;
    logic              w_row_end;
    logic [ROW_AW:0]   w_row_ext;

    assign w_row_end   = (r_elem == c_LAST_E);
    assign w_row_ext   = {1'b0, r_row};
    assign o_row       = r_row;
    assign o_clear_row = i_accept & (r_elem == '0);
    assign o_last      = i_accept & w_row_end & (r_row == c_LAST_R);

    // A flush sees the bank after the same-cycle write, so an accepted beat
    // makes the bank flushable and always leaves exactly r+1 rows touched.
    assign o_commit      = i_flush & (i_bank_filling | i_accept) & ~o_last;
    assign o_commit_rows = i_accept ? (w_row_ext + RW1'(1))
                                    : (w_row_ext + RW1'(r_elem != '0));

    for (genvar k = 0; k < ROW_ELEMS; k++) begin : g_lane
        assign o_lane_we[k] = i_accept & (r_elem == E_W'(k));
    end

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_elem <= '0;
            r_row  <= '0;
        end else if (o_last || o_commit) begin
            r_elem <= '0;
            r_row  <= '0;
        end else if (i_accept) begin
            if (w_row_end) begin
                r_elem <= '0;
                r_row  <= r_row + ROW_AW'(1);
            end else begin
                r_elem <= r_elem + E_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/coproc_batch_buffer.sv
`default_nettype none
// ============================================================================
// Module   : coproc_batch_buffer
// Purpose  : Two-bank ping-pong batch buffer between the soft-CPU write path
//            and the systolic-array row read port.
// Revision : 1.0 - initial release
// ============================================================================
module coproc_batch_buffer
    import coproc_batch_pkg::*;
#(
    parameter int ELEM_W    = DEF_ELEM_W,
    parameter int ROW_ELEMS = DEF_ROW_ELEMS,
    parameter int ROWS      = DEF_ROWS,
    parameter int ROW_AW    = idx_width(ROWS)
)(
    input  logic                          i_clk,
    input  logic                          i_clr,
    input  logic                          i_wr_valid,
    input  logic [ELEM_W-1:0]             i_wr_data,
    output logic                          o_wr_ready,
    input  logic                          i_flush,
    input  logic [ROW_AW-1:0]             i_rd_row,
    output logic [ELEM_W*ROW_ELEMS-1:0]   o_rd_data,
    output logic                          o_rd_ready,
    input  logic                          i_rd_done,
    output logic [ROW_AW:0]               o_rows_valid,
    output logic                          o_overflow
);

    localparam int ROW_W = ELEM_W * ROW_ELEMS;
    localparam int RW1   = ROW_AW + 1;
    localparam logic [ROW_AW:0] c_ROWS = RW1'(ROWS);

    bank_state_t        r_state     [2];
    bank_state_t        w_state_nxt [2];
    logic [ROW_AW:0]    r_rows_wr   [2];
    logic [ROW_AW:0]    w_rows_nxt  [2];
    logic               r_wb;
    logic               r_rb;
    logic [ROW_W-1:0]   r_mem [2][ROWS];

    logic                 w_accept;
    logic                 w_release;
    logic                 w_close;
    logic                 w_rd_hit;
    logic [ROW_AW-1:0]    w_row;
    logic [ROW_ELEMS-1:0] w_lane_we;
    logic                 w_clear_row;
    logic                 w_last;
    logic                 w_commit;
    logic [ROW_AW:0]      w_commit_rows;

    assign o_wr_ready   = (r_state[r_wb] != FULL);
    assign o_rd_ready   = (r_state[r_rb] == FULL);
    assign o_rows_valid = o_rd_ready ? r_rows_wr[r_rb] : '0;
    assign w_accept     = i_wr_valid & o_wr_ready;
    assign w_release    = i_rd_done & o_rd_ready;
    assign w_close      = w_last | w_commit;

    coproc_batch_packer #(
        .ROW_ELEMS (ROW_ELEMS),
        .ROWS      (ROWS),
        .ROW_AW    (ROW_AW)
    ) u_packer (
        .i_clk          (i_clk),
        .i_clr          (i_clr),
        .i_accept       (w_accept),
        .i_flush        (i_flush),
        .i_bank_filling (r_state[r_wb] == FILLING),
        .o_row          (w_row),
        .o_lane_we      (w_lane_we),
        .o_clear_row    (w_clear_row),
        .o_last         (w_last),
        .o_commit       (w_commit),
        .o_commit_rows  (w_commit_rows)
    );

    // When wb == rb no release and close can coincide, so the indexed
    // updates below never collide on the same bank.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            w_state_nxt[b] = r_state[b];
            w_rows_nxt[b]  = r_rows_wr[b];
        end
        if (w_accept && r_state[r_wb] == EMPTY) begin
            w_state_nxt[r_wb] = FILLING;
        end
        if (w_close) begin
            w_state_nxt[r_wb] = FULL;
            w_rows_nxt[r_wb]  = w_last ? c_ROWS : w_commit_rows;
        end
        if (w_release) begin
            w_state_nxt[r_rb] = EMPTY;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            for (int b = 0; b < 2; b++) begin
                r_state[b]   <= EMPTY;
                r_rows_wr[b] <= '0;
            end
            r_wb       <= 1'b0;
            r_rb       <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                r_state[b]   <= w_state_nxt[b];
                r_rows_wr[b] <= w_rows_nxt[b];
            end
            if (w_close)   r_wb <= ~r_wb;
            if (w_release) r_rb <= ~r_rb;
            if (i_wr_valid && !o_wr_ready) o_overflow <= 1'b1;
        end
    end

    // Starting a row clears its unused lanes so a flushed partial row pads with zeros.
    always_ff @(posedge i_clk) begin
        for (int k = 0; k < ROW_ELEMS; k++) begin
            if (w_lane_we[k]) begin
                r_mem[r_wb][w_row][k*ELEM_W +: ELEM_W] <= i_wr_data;
            end else if (w_clear_row) begin
                r_mem[r_wb][w_row][k*ELEM_W +: ELEM_W] <= '0;
            end
        end
    end

    assign w_rd_hit = o_rd_ready
                    && ({1'b0, i_rd_row} < r_rows_wr[r_rb])
                    && ({1'b0, i_rd_row} < c_ROWS);

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            o_rd_data <= '0;
        end else begin
            o_rd_data <= w_rd_hit ? r_mem[r_rb][i_rd_row] : '0;
        end
    end

endmodule
`default_nettype wire
